// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V hazard scoreboard.
// The entry-state enum is derived from outs/cnt, not stored.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        FWDABLE = 2'd2
    } ent_state_e;

    localparam int OUTS_MAX    = 3;
    localparam int MAX_LAT_DEF = 4;
    localparam int LAT_ALU     = 1;
    localparam int LAT_LOAD    = 2;
    localparam int LAT_MUL     = MAX_LAT_DEF;

endpackage

// File: rtl/riscv_hazard_scoreboard_if.sv
// Decode/writeback <-> scoreboard bundle. The decode side is the master; the
// scoreboard is the slave.
interface riscv_hazard_scoreboard_if #(
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int LAT_W = 3
);
    logic             issue_valid;
    logic             issue_ready;
    logic [AW-1:0]    issue_rs1;
    logic [AW-1:0]    issue_rs2;
    logic             issue_use_rs1;
    logic             issue_use_rs2;
    logic             issue_we;
    logic [AW-1:0]    issue_rd;
    logic [LAT_W-1:0] issue_lat;
    logic             flush;
    logic             wb_valid;
    logic [AW-1:0]    wb_rd;
    logic             rs1_fwd;
    logic             rs2_fwd;
    logic             stall_raw;
    logic             stall_waw;
    logic [NREGS-1:0] busy;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
               issue_we, issue_rd, issue_lat, flush, wb_valid, wb_rd,
        input  issue_ready, rs1_fwd, rs2_fwd, stall_raw, stall_waw, busy
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
               issue_we, issue_rd, issue_lat, flush, wb_valid, wb_rd,
        output issue_ready, rs1_fwd, rs2_fwd, stall_raw, stall_waw, busy
    );

endinterface

// File: rtl/riscv_hazard_scoreboard_sb_entry.sv
// Per-register scoreboard entry: outstanding-write count, forwarding countdown
// and the "issued last cycle" marker that a flush uses to squash the shadow write.
module sb_entry
    import riscv_pkg::*;
#(
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iss,
    input  logic [LAT_W-1:0] iss_lat,
    input  logic             wb,
    input  logic             flush,
    output ent_state_e       state,
    output logic             full
);
    logic [1:0]       outs, outs_n, outs_k;
    logic [LAT_W-1:0] cnt, cnt_n;
    logic             young, young_n;
    logic             kill, wb_dec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outs  <= '0;
            cnt   <= '0;
            young <= 1'b0;
        end else begin
            outs  <= outs_n;
            cnt   <= cnt_n;
            young <= young_n;
        end
    end

    always_comb begin
        kill    = flush && young;
        // A squashed write is removed first so a same-cycle writeback cannot underflow.
        outs_k  = outs - {1'b0, kill};
        wb_dec  = wb && (outs_k != 2'd0);
        outs_n  = outs_k + {1'b0, iss} - {1'b0, wb_dec};
        young_n = iss;
        cnt_n   = (cnt != '0) ? cnt - LAT_W'(1) : '0;
        if (kill) cnt_n = '0;
        // The load already absorbs this edge's decrement.
        if (iss)  cnt_n = iss_lat - LAT_W'(1);

        state = IDLE;
        if (outs != 2'd0) state = (cnt != '0) ? PENDING : FWDABLE;
        full = (outs == 2'(OUTS_MAX));
    end

endmodule

// File: rtl/riscv_hazard_scoreboard.sv
// Scoreboard hazard controller: per-register entries plus RAW/WAW reduction,
// issue gating and bypass select. Optional SCOREBOARD_PERF_EN adds a stall counter.
module riscv_hazard_scoreboard
    import riscv_pkg::*;
#(
    parameter int NREGS   = 32,
    parameter int AW      = 5,
    parameter int MAX_LAT = MAX_LAT_DEF,
    parameter int LAT_W   = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    riscv_hazard_scoreboard_if.slave  sb
`ifdef SCOREBOARD_PERF_EN
    ,
    output logic [31:0]               perf_stall_cycles
`endif
);
    logic [NREGS-1:0] pend, fwdb, full, busy_v;
    logic [LAT_W-1:0] lat_eff;
    logic             raw, waw, ready, accept;

    always_comb begin
        lat_eff = sb.issue_lat;
        if (sb.issue_lat == '0)                   lat_eff = LAT_W'(1);
        else if (sb.issue_lat > LAT_W'(MAX_LAT))  lat_eff = LAT_W'(MAX_LAT);
    end

    // x0 has no entry; its slots read as IDLE so it never stalls or forwards.
    assign pend[0]   = 1'b0;
    assign fwdb[0]   = 1'b0;
    assign full[0]   = 1'b0;
    assign busy_v[0] = 1'b0;

    for (genvar r = 1; r < NREGS; r++) begin : g_ent
        ent_state_e st;

        sb_entry #(.LAT_W(LAT_W)) u_ent (
            .clk     (clk),
            .rst     (rst),
            .iss     (accept && sb.issue_we && (sb.issue_rd == AW'(r))),
            .iss_lat (lat_eff),
            .wb      (sb.wb_valid && (sb.wb_rd == AW'(r))),
            .flush   (sb.flush),
            .state   (st),
            .full    (full[r])
        );

        assign pend[r]   = (st == PENDING);
        assign fwdb[r]   = (st == FWDABLE);
        assign busy_v[r] = (st != IDLE);
    end

    always_comb begin
        raw    = (sb.issue_use_rs1 && pend[sb.issue_rs1]) ||
                 (sb.issue_use_rs2 && pend[sb.issue_rs2]);
        waw    = sb.issue_we && (pend[sb.issue_rd] || full[sb.issue_rd]);
        ready  = !raw && !waw && !sb.flush;
        accept = sb.issue_valid && ready;
    end

    assign sb.issue_ready = ready;
    assign sb.stall_raw   = raw;
    assign sb.stall_waw   = waw;
    assign sb.rs1_fwd     = sb.issue_use_rs1 && fwdb[sb.issue_rs1];
    assign sb.rs2_fwd     = sb.issue_use_rs2 && fwdb[sb.issue_rs2];
    assign sb.busy        = busy_v;

`ifdef SCOREBOARD_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            perf_stall_cycles <= '0;
        else if (sb.issue_valid && !ready)
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_riscv_hazard_scoreboard.sv
// Directed test-plan scenarios plus random traffic against a cycle-number model
// of the scoreboard (outstanding count, cycle the newest write becomes forwardable).
module tb_riscv_hazard_scoreboard;
    import riscv_pkg::*;

    localparam int NREGS   = 32;
    localparam int AW      = 5;
    localparam int MAX_LAT = 4;
    localparam int LAT_W   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    riscv_hazard_scoreboard_if #(.NREGS(NREGS), .AW(AW), .LAT_W(LAT_W)) sb ();
`ifdef SCOREBOARD_PERF_EN
    logic [31:0] perf;
`endif

    riscv_hazard_scoreboard #(.NREGS(NREGS), .AW(AW), .MAX_LAT(MAX_LAT), .LAT_W(LAT_W)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb)
`ifdef SCOREBOARD_PERF_EN
        ,
        .perf_stall_cycles (perf)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    // model: outstanding writes, cycle newest write is forwardable, cycle of last accepted issue
    int m_outs[NREGS];
    int m_rdy[NREGS];
    int m_last[NREGS];
    int now;
    logic [31:0] m_perf;

    bit d_v, d_u1, d_u2, d_we, d_fl, d_wv;
    int d_r1, d_r2, d_rd, d_lat, d_wrd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_pend(int r);
        return r != 0 && m_outs[r] > 0 && now < m_rdy[r];
    endfunction

    function automatic bit m_fwdb(int r);
        return r != 0 && m_outs[r] > 0 && now >= m_rdy[r];
    endfunction

    function automatic bit e_raw();
        return (d_u1 && m_pend(d_r1)) || (d_u2 && m_pend(d_r2));
    endfunction

    function automatic bit e_waw();
        return d_we && d_rd != 0 && (m_pend(d_rd) || m_outs[d_rd] == OUTS_MAX);
    endfunction

    function automatic bit e_ready();
        return !e_raw() && !e_waw() && !d_fl;
    endfunction

    function automatic logic [31:0] e_busy();
        logic [31:0] b = '0;
        for (int r = 1; r < NREGS; r++) b[r] = (m_outs[r] > 0);
        return b;
    endfunction

    task automatic m_reset();
        for (int r = 0; r < NREGS; r++) begin
            m_outs[r] = 0;
            m_rdy[r]  = 0;
            m_last[r] = -10;
        end
        m_perf = '0;
    endtask

    task automatic drive(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                         input bit we, input int rd, input int lat, input bit fl,
                         input bit wv, input int wrd);
        d_v = v; d_r1 = r1; d_u1 = u1; d_r2 = r2; d_u2 = u2;
        d_we = we; d_rd = rd; d_lat = lat; d_fl = fl; d_wv = wv; d_wrd = wrd;
        sb.issue_valid   = v;
        sb.issue_rs1     = AW'(r1);
        sb.issue_use_rs1 = u1;
        sb.issue_rs2     = AW'(r2);
        sb.issue_use_rs2 = u2;
        sb.issue_we      = we;
        sb.issue_rd      = AW'(rd);
        sb.issue_lat     = LAT_W'(lat);
        sb.flush         = fl;
        sb.wb_valid      = wv;
        sb.wb_rd         = AW'(wrd);
        #2;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_model();
        chk("ready", 32'(sb.issue_ready), 32'(e_ready()));
        chk("stall_raw", 32'(sb.stall_raw), 32'(e_raw()));
        chk("stall_waw", 32'(sb.stall_waw), 32'(e_waw()));
        chk("busy", sb.busy, e_busy());
        if (d_v) begin
            chk("rs1_fwd", 32'(sb.rs1_fwd), 32'(d_u1 && m_fwdb(d_r1)));
            chk("rs2_fwd", 32'(sb.rs2_fwd), 32'(d_u2 && m_fwdb(d_r2)));
        end
`ifdef SCOREBOARD_PERF_EN
        chk("perf", perf, m_perf);
`endif
    endtask

    task automatic advance();
        int  leff;
        bit  acc;
        leff = (d_lat == 0) ? 1 : (d_lat > MAX_LAT ? MAX_LAT : d_lat);
        acc  = d_v && e_ready();
        if (d_v && !acc) m_perf = m_perf + 32'd1;
        for (int r = 1; r < NREGS; r++)
            if (d_fl && m_last[r] == now - 1 && m_outs[r] > 0) begin
                m_outs[r]--;
                m_rdy[r] = now;
            end
        if (d_wv && d_wrd != 0 && m_outs[d_wrd] > 0) m_outs[d_wrd]--;
        if (acc && d_we && d_rd != 0) begin
            m_outs[d_rd]++;
            m_rdy[d_rd]  = now + leff;
            m_last[d_rd] = now;
        end
        @(posedge clk);
        #1;
        now++;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        #1;
        chk("rst_busy", sb.busy, 32'h0);
        m_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        now = 0;
    endtask

    initial begin
        m_reset();
        now = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("rst_ready_flush", 32'(sb.issue_ready), 32'h0);
        idle();
        chk("rst_ready", 32'(sb.issue_ready), 32'h1);
        chk("rst_busy0", sb.busy, 32'h0);
        chk("rst_stalls", {30'h0, sb.stall_raw, sb.stall_waw}, 32'h0);
`ifdef SCOREBOARD_PERF_EN
        chk("rst_perf", perf, 32'h0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // x5 load-use: stall one cycle, then forward
        drive(1, 0, 0, 0, 0, 1, 5, LAT_LOAD, 0, 0, 0); check_model(); advance();
        drive(1, 5, 1, 0, 0, 0, 0, 1, 0, 0, 0); check_model();
        chk("x5_stall_ready", 32'(sb.issue_ready), 32'h0);
        chk("x5_stall_raw", 32'(sb.stall_raw), 32'h1);
        advance();
        drive(1, 5, 1, 0, 0, 0, 0, 1, 0, 0, 0); check_model();
        chk("x5_ready", 32'(sb.issue_ready), 32'h1);
        chk("x5_fwd", 32'(sb.rs1_fwd), 32'h1);
        advance();
        do_reset();

        // x0 is never tracked
        drive(1, 0, 0, 0, 0, 1, 0, 4, 0, 0, 0); check_model(); advance();
        drive(1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0); check_model();
        chk("x0_ready", 32'(sb.issue_ready), 32'h1);
        chk("x0_fwd", 32'(sb.rs1_fwd), 32'h0);
        chk("x0_busy", sb.busy, 32'h0);
        advance();
        do_reset();

        // x7 three outstanding writes saturate the counter
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 0, 0, 1, 7, LAT_ALU, 0, 0, 0); check_model();
            chk("x7_accept", 32'(sb.issue_ready), 32'h1);
            advance();
        end
        drive(1, 0, 0, 0, 0, 1, 7, LAT_ALU, 0, 1, 7); check_model();
        chk("x7_waw", 32'(sb.stall_waw), 32'h1);
        advance();
        drive(1, 0, 0, 0, 0, 1, 7, LAT_ALU, 0, 0, 0); check_model();
        chk("x7_fourth", 32'(sb.issue_ready), 32'h1);
        advance();
        do_reset();

        // x3 issue and writeback in the same cycle
        drive(1, 0, 0, 0, 0, 1, 3, LAT_ALU, 0, 0, 0); check_model(); advance();
        drive(1, 0, 0, 0, 0, 1, 3, LAT_ALU, 0, 1, 3); check_model(); advance();
        idle(); check_model();
        chk("x3_busy", 32'(sb.busy[3]), 32'h1);
        advance();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3); check_model(); advance();
        idle(); check_model();
        chk("x3_clear", 32'(sb.busy[3]), 32'h0);
        advance();
        do_reset();

        // x9 shadow write killed by flush
        drive(1, 0, 0, 0, 0, 1, 9, LAT_MUL, 0, 0, 0); check_model(); advance();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); check_model(); advance();
        drive(1, 9, 1, 0, 0, 0, 0, 1, 0, 0, 0); check_model();
        chk("x9_busy", 32'(sb.busy[9]), 32'h0);
        chk("x9_ready", 32'(sb.issue_ready), 32'h1);
        chk("x9_fwd", 32'(sb.rs1_fwd), 32'h0);
        advance();

        // four busy registers, stalled reader, then asynchronous reset
        drive(1, 0, 0, 0, 0, 1, 1, LAT_MUL, 0, 0, 0); check_model(); advance();
        drive(1, 0, 0, 0, 0, 1, 2, LAT_MUL, 0, 0, 0); check_model(); advance();
        drive(1, 0, 0, 0, 0, 1, 4, LAT_MUL, 0, 0, 0); check_model(); advance();
        drive(1, 0, 0, 0, 0, 1, 6, LAT_MUL, 0, 0, 0); check_model(); advance();
        for (int k = 0; k < 2; k++) begin
            drive(1, 6, 1, 0, 0, 0, 0, 1, 0, 0, 0); check_model(); advance();
        end
        idle(); check_model();
        chk("four_busy", sb.busy, 32'h0000_0056);
        rst = 1'b1;
        #1;
        chk("async_busy", sb.busy, 32'h0);
`ifdef SCOREBOARD_PERF_EN
        chk("async_perf", perf, 32'h0);
`endif
        do_reset();

        // random traffic over x0..x7
        for (int c = 0; c < 3000; c++) begin
            int cand[$];
            int wrd;
            bit wv;
            cand = {};
            for (int r = 1; r < 8; r++) if (m_outs[r] > 0) cand.push_back(r);
            wv  = ($urandom_range(0, 9) < 4);
            wrd = (cand.size() > 0 && $urandom_range(0, 9) < 8)
                  ? cand[$urandom_range(0, cand.size() - 1)] : int'($urandom_range(0, 7));
            drive($urandom_range(0, 3) != 0,
                  $urandom_range(0, 7), $urandom_range(0, 1),
                  $urandom_range(0, 7), $urandom_range(0, 1),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 11) == 0, wv, wrd);
            check_model();
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
